pp_preprocess_pipe: RTL and testbench
=====================================

Name: pp_preprocess_pipe

Overview:
- Parametrised, pipelined pre-processing stage for the approximate parallel-prefix adder family.
- Takes operands a, b, carry-in and an add/subtract mode. Produces folded propagate/generate vectors (carry-in folded into bit 0, b shifted up one position) for the prefix tree.
- Adds a valid/ready handshake and a 2-entry skid buffer, so the prefix tree can back-pressure without dropping operands.
- Adds an optional approximate low-order region in which generate is forced to zero.

Parameters:
- WIDTH, 16, operand width in bits (legal range 4..64).
- APPROX_BITS, 0, number of low-order folded positions computed approximately (0..WIDTH-1; 0 means exact).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  stage can accept a beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1).
- out_valid  output  1  p/g beat present.
- out_ready  input  1  downstream accepts beat.
- p  output  WIDTH  folded propagate.
- g  output  WIDTH+1  folded generate; bit WIDTH is the top operand bit.
- beats  output  32  count of accepted output beats, wraps at 2^32.

Behaviour:
- Operand conditioning (combinational, input side):
  - bx = sub ? ~b : b
  - cx = sub ? 1 : cin
  - q = {bx[WIDTH-2:0], cx}, i.e. the shifted B vector with the carry in bit 0.
- Exact positions, i >= APPROX_BITS: p[i] = a[i] ^ q[i]; g[i] = a[i] & q[i].
- Approximate positions, i < APPROX_BITS: p[i] = a[i] | q[i]; g[i] = 0.
- Top bit: g[WIDTH] = bx[WIDTH-1], independent of APPROX_BITS.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Latency: a beat accepted in cycle N is visible on p/g with out_valid=1 in cycle N+1 at the earliest. p/g are driven from registers only.
- Throughput: one beat per cycle while out_ready=1.
- Storage is a 2-entry skid buffer with states EMPTY, ONE, FULL:
  - EMPTY: in_ready=1, out_valid=0. Input transfer -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Input and output transfer together -> ONE, with the new beat on the output.
    - Input transfer only -> FULL.
    - Output transfer only -> EMPTY.
  - FULL: in_ready=0, out_valid=1. Output transfer -> ONE, with the skid entry promoted.
- in_ready is a registered function of state: 1 in EMPTY/ONE, 0 in FULL. It never depends combinationally on out_ready.
- While out_valid=1 and out_ready=0, p/g hold stable (no change until the transfer).
- in_valid while in_ready=0: the beat is not taken; the source must hold it.
- beats increments on each output transfer and wraps from 0xFFFFFFFF to 0.
- Reset (asynchronous assert, any cycle including mid-stream):
  - State -> EMPTY; out_valid=0; in_ready=1.
  - p=0, g=0, beats=0.
  - In-flight beats are discarded.
  - Release is synchronised by the integrator; the block takes no beat in the first cycle after deassertion.
- Ordering: strict FIFO; beats are never reordered or duplicated.

Decomposition:
- Shared package pp_pkg:
  - PP_MAX_WIDTH = 64.
  - Skid state enum (EMPTY, ONE, FULL).
  - Function pp_fold(a, b, cin, sub, approx) returning {g, p}. It is reused by the later 32/64-bit adder tops and by the scoreboard model.
- One natural sub-module: pp_skid_buffer, parametrised on payload width (2*WIDTH+1). It owns the state machine and the in_ready/out_valid logic.
- Folding logic stays inline in pp_preprocess_pipe, on the input side of pp_skid_buffer.

Test Plan:
- Exact add, WIDTH=16, APPROX_BITS=0: a=0x00FF, b=0x0001, cin=1, sub=0, out_ready=1 -> next cycle out_valid=1, p=0x00FC, g=0x00003, beats=1.
- Subtract: a=0x0005, b=0x0003, sub=1, cin=0 -> bx=0xFFFC, q=0xFFF9; p=0xFFFC, g=0x10001; the prefix tree's downstream sum is 0x0002.
- Approximate region, APPROX_BITS=4: a=0x000F, b=0x0007, cin=1 -> p[3:0]=0xF, g[3:0]=0; bits >=4 match the exact model.
- Back-pressure: stream 5 beats with out_ready=0 -> accept 2, in_ready=0 on cycle 3, output holds beat 0. Raise out_ready -> beats emerge in order 0..4, one per cycle, none lost.
- Reset mid-stream: FULL state, assert rst asynchronously between edges -> out_valid, p, g, beats clear immediately; in_ready=1; the next accepted beat is the first seen at the output.
- Counter wrap: preload via 2^32 transfers in a forced-state sim (or a shortened-width build) -> beats rolls 0xFFFFFFFF -> 0 on the next output transfer.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared definitions for the approximate parallel-prefix adder family:
// skid-buffer state encoding and the operand folding function.
package pp_pkg;

    localparam int PP_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [PP_MAX_WIDTH:0]   g;
        logic [PP_MAX_WIDTH-1:0] p;
    } pp_fold_t;

    // Operands are right-aligned in PP_MAX_WIDTH bits; everything at or above
    // 'width' is returned as zero except the top generate bit g[width].
    function automatic pp_fold_t pp_fold(
        input logic [PP_MAX_WIDTH-1:0] a,
        input logic [PP_MAX_WIDTH-1:0] b,
        input logic                    cin,
        input logic                    sub,
        input int                      width,
        input int                      approx
    );
        logic [PP_MAX_WIDTH-1:0] bx;
        logic [PP_MAX_WIDTH-1:0] q;
        logic [PP_MAX_WIDTH-1:0] width_mask;
        logic [PP_MAX_WIDTH-1:0] approx_mask;
        logic [PP_MAX_WIDTH-1:0] exact_p;
        logic [PP_MAX_WIDTH-1:0] exact_g;
        logic [PP_MAX_WIDTH-1:0] apx_p;
        logic [PP_MAX_WIDTH-1:0] g_low;
        pp_fold_t                r;

        bx          = sub ? ~b : b;
        q           = {bx[PP_MAX_WIDTH-2:0], (sub ? 1'b1 : cin)};
        width_mask  = (width >= PP_MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        approx_mask = (64'd1 << approx) - 64'd1;

        exact_p = a ^ q;
        exact_g = a & q;
        apx_p   = a | q;

        r.p   = ((exact_p & ~approx_mask) | (apx_p & approx_mask)) & width_mask;
        g_low = exact_g & ~approx_mask & width_mask;
        r.g   = {1'b0, g_low} | (65'(bx[6'(width - 1)]) << width);
        return r;
    endfunction

endpackage

// File: rtl/pp_preprocess_pipe_if.sv
// Operand-in / propagate-generate-out handshake bundle for pp_preprocess_pipe.
interface pp_preprocess_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   g;

    // master = operand source and p/g consumer, slave = the pre-process stage
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, p, g
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, p, g
    );
endinterface

// File: rtl/pp_skid_buffer.sv
// Two-entry skid buffer: registered in_ready/out_valid, output driven from
// the head register, a second register absorbs one beat of back-pressure.
module pp_skid_buffer
    import pp_pkg::*;
#(
    parameter int DATA_W = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (in_xfer) begin
                    head_d  = in_data;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (in_xfer && out_xfer) begin
                    head_d = in_data;
                end else if (in_xfer) begin
                    skid_d  = in_data;
                    state_d = SKID_FULL;
                end else if (out_xfer) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only the drain path exists
                if (out_xfer) begin
                    head_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        in_ready_d  = (state_d != SKID_FULL);
        out_valid_d = (state_d != SKID_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SKID_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q;

endmodule

// File: rtl/pp_preprocess_pipe.sv
// Pre-processing stage of the approximate prefix adder: folds a/b/cin/sub into
// propagate/generate vectors and hands them to the prefix tree via a skid buffer.
module pp_preprocess_pipe
    import pp_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    pp_preprocess_pipe_if.slave  bus,
    output logic [31:0]          beats
);

    localparam int PAYLOAD_W = 2 * WIDTH + 1;

    logic [PP_MAX_WIDTH-1:0] a_ext;
    logic [PP_MAX_WIDTH-1:0] b_ext;
    pp_fold_t                fold;
    logic [PAYLOAD_W-1:0]    fold_payload;
    logic [PAYLOAD_W-1:0]    out_payload;
    logic                    unused_fold;
    logic                    out_xfer;
    logic [31:0]             beats_q, beats_d;

    // Input side: fold operands before they enter storage
    always_comb begin
        a_ext                = '0;
        b_ext                = '0;
        a_ext[WIDTH-1:0]     = bus.a;
        b_ext[WIDTH-1:0]     = bus.b;
        fold                 = pp_fold(a_ext, b_ext, bus.cin, bus.sub, WIDTH, APPROX_BITS);
        fold_payload         = {fold.g[WIDTH:0], fold.p[WIDTH-1:0]};
    end

    assign unused_fold = ^fold;

    pp_skid_buffer #(
        .DATA_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (fold_payload),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_payload)
    );

    assign bus.p = out_payload[WIDTH-1:0];
    assign bus.g = out_payload[PAYLOAD_W-1:WIDTH];

    // Output side: count beats taken by the prefix tree
    assign out_xfer = bus.out_valid & bus.out_ready;
    assign beats_d  = beats_q + {31'b0, out_xfer};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_q <= '0;
        end else begin
            beats_q <= beats_d;
        end
    end

    assign beats = beats_q;

endmodule

// File: tb/tb_pp_preprocess_pipe.sv
// Scoreboard bench for pp_preprocess_pipe: an exact and an approximate build,
// hand-computed {g,p} expectations queued at acceptance, popped by monitors.
module tb_pp_preprocess_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] beats0;
    logic [31:0] beats1;

    always #5 clk = ~clk;

    pp_preprocess_pipe_if #(.WIDTH(16)) bus0 ();
    pp_preprocess_pipe_if #(.WIDTH(16)) bus1 ();

    pp_preprocess_pipe #(.WIDTH(16), .APPROX_BITS(0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus0),
        .beats (beats0)
    );

    pp_preprocess_pipe #(.WIDTH(16), .APPROX_BITS(4)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus1),
        .beats (beats1)
    );

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] e0;
    logic [32:0] e1;
    int          checks   = 0;
    int          failures = 0;
    bit          bp_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut0_extra_beat: got g=0x%0h p=0x%0h expected no beat", bus0.g, bus0.p);
            end else begin
                e0 = q0.pop_front();
                check("dut0_gp", 64'({bus0.g, bus0.p}), 64'(e0));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_extra_beat: got g=0x%0h p=0x%0h expected no beat", bus1.g, bus1.p);
            end else begin
                e1 = q1.pop_front();
                check("dut1_gp", 64'({bus1.g, bus1.p}), 64'(e1));
            end
        end
    end

    task automatic send0(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic [32:0] exp);
        bit ok = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.a = a;
        bus0.b = b;
        bus0.cin = cin;
        bus0.sub = sub;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus0.in_ready;
            @(posedge clk);
            #1;
        end
        bus0.in_valid = 1'b0;
        if (ok) q0.push_back(exp);
        else begin
            checks++;
            failures++;
            $display("FAIL send0_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic [32:0] exp);
        bit ok = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.a = a;
        bus1.b = b;
        bus1.cin = cin;
        bus1.sub = sub;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus1.in_ready;
            @(posedge clk);
            #1;
        end
        bus1.in_valid = 1'b0;
        if (ok) q1.push_back(exp);
        else begin
            checks++;
            failures++;
            $display("FAIL send1_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            if (q0.size() == 0 && q1.size() == 0 && !bus0.out_valid && !bus1.out_valid) done = 1'b1;
            else begin
                @(posedge clk);
                #2;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_drain: got %0d/%0d beats pending expected 0", name, q0.size(), q1.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
        bus1.out_ready = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus0.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("rst_p", 64'(bus0.p), 64'd0);
        check("rst_g", 64'(bus0.g), 64'd0);
        check("rst_beats", 64'(beats0), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // exact add, then subtract back-to-back
        bus0.out_ready = 1'b1;
        send0(16'h00FF, 16'h0001, 1'b1, 1'b0, 33'h0_0003_00FC);
        check("latency_out_valid", 64'(bus0.out_valid), 64'd1);
        send0(16'h0005, 16'h0003, 1'b0, 1'b1, 33'h1_0001_FFFC);
        drain("add_sub");
        check("beats_after_two", 64'(beats0), 64'd2);

        // approximate low nibble
        bus1.out_ready = 1'b1;
        send1(16'h000F, 16'h0007, 1'b1, 1'b0, 33'h0_0000_000F);
        send1(16'h00F5, 16'h0053, 1'b0, 1'b0, 33'h0_00A0_0057);
        drain("approx");

        // back-pressure: five beats against a stalled consumer
        bus0.out_ready = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                send0(16'h0001, 16'h0001, 1'b0, 1'b0, 33'h0_0000_0003);
                send0(16'h0002, 16'h0002, 1'b0, 1'b0, 33'h0_0000_0006);
                send0(16'h0003, 16'h0003, 1'b0, 1'b0, 33'h0_0002_0005);
                send0(16'h0004, 16'h0004, 1'b0, 1'b0, 33'h0_0000_000C);
                send0(16'h8000, 16'h8000, 1'b0, 1'b0, 33'h1_0000_8000);
                bp_done = 1'b1;
            end
        join_none
        repeat (2) @(posedge clk);
        #2;
        check("bp_in_ready_low", 64'(bus0.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus0.out_valid), 64'd1);
        check("bp_head_p", 64'(bus0.p), 64'h0003);
        repeat (3) @(posedge clk);
        #2;
        check("bp_hold_p", 64'(bus0.p), 64'h0003);
        check("bp_hold_g", 64'(bus0.g), 64'h0);
        check("bp_hold_in_ready", 64'(bus0.in_ready), 64'd0);
        bus0.out_ready = 1'b1;
        for (int n = 0; n < 100 && !bp_done; n++) begin
            @(posedge clk);
            #1;
        end
        if (!bp_done) begin
            checks++;
            failures++;
            $display("FAIL bp_sender: got sender stalled expected 5 beats accepted");
        end
        drain("backpressure");
        check("beats_after_bp", 64'(beats0), 64'd7);

        // counter wrap from a preloaded all-ones value
        @(posedge clk);
        #1;
        force dut0.beats_q = 32'hFFFF_FFFF;
        #1;
        release dut0.beats_q;
        #1;
        check("wrap_preload", 64'(beats0), 64'hFFFF_FFFF);
        send0(16'h00FF, 16'h0001, 1'b1, 1'b0, 33'h0_0003_00FC);
        drain("wrap");
        check("wrap_to_zero", 64'(beats0), 64'd0);

        // asynchronous reset while FULL
        bus0.out_ready = 1'b0;
        send0(16'h0005, 16'h0003, 1'b0, 1'b1, 33'h1_0001_FFFC);
        send0(16'h00FF, 16'h0001, 1'b1, 1'b0, 33'h0_0003_00FC);
        check("full_in_ready", 64'(bus0.in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        q0.delete();
        check("amid_out_valid", 64'(bus0.out_valid), 64'd0);
        check("amid_in_ready", 64'(bus0.in_ready), 64'd1);
        check("amid_p", 64'(bus0.p), 64'd0);
        check("amid_g", 64'(bus0.g), 64'd0);
        check("amid_beats", 64'(beats0), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
        send0(16'h0003, 16'h0003, 1'b0, 1'b0, 33'h0_0002_0005);
        drain("post_reset");
        check("post_reset_beats", 64'(beats0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
